// File: rtl/dbus_access_ctrl.sv
// dbus_access_ctrl: one outstanding data-bus transaction per memory instruction; latches the request,
// holds it until data_ok, registers the load word and stalls upstream. Watchdog option: DBUS_TIMEOUT_EN.

typedef struct packed {
  logic        valid;
  logic [63:0] addr;
  logic [2:0]  size;
  logic [7:0]  strobe;
  logic [63:0] data;
} dbus_req_t;

typedef struct packed {
  logic        addr_ok;
  logic        data_ok;
  logic [63:0] data;
} dbus_resp_t;

module dbus_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_flush,
  input  dbus_req_t   i_mreq,
  output dbus_req_t   o_dreq,
  input  dbus_resp_t  i_dresp,
  output logic        o_stall_m,
  output logic [63:0] o_rdata,
  output logic        o_done,
  output logic        o_bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [63:0] r_addr;
  logic [2:0]  r_size;
  logic [7:0]  r_strobe;
  logic [63:0] r_data;
  logic        r_kill;
  logic [63:0] r_rdata;
  logic        w_accept;
  logic        w_timeout;
  logic        w_unused;

  assign w_accept = (r_state == S_IDLE) && i_mreq.valid && !i_flush;

  // addr_ok never advances the FSM; data_ok alone completes a transaction.
  assign w_unused = &{1'b0, i_dresp.addr_ok, (TIMEOUT_CYCLES != 0)};

`ifdef DBUS_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_timer;
  logic          r_bus_err;

  // Fires on the last of TIMEOUT_CYCLES BUSY cycles if the bus is still silent.
  assign w_timeout = (r_state == S_BUSY) && !i_dresp.data_ok &&
                     (r_timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_timer   <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_accept)
        r_timer <= '0;
      else if (r_state == S_BUSY)
        r_timer <= r_timer + 1'b1;
      if (w_timeout)
        r_bus_err <= 1'b1;
    end
  end

  assign o_bus_err = r_bus_err;
`else
  assign w_timeout = 1'b0;
  assign o_bus_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_BUSY;
      S_BUSY:  if (i_dresp.data_ok || w_timeout) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_dreq    = '0;
    o_stall_m = 1'b0;
    o_done    = 1'b0;
    case (r_state)
      S_IDLE: o_stall_m = i_mreq.valid && !i_flush;
      S_BUSY: begin
        o_dreq.valid  = 1'b1;
        o_dreq.addr   = r_addr;
        o_dreq.size   = r_size;
        o_dreq.strobe = r_strobe;
        o_dreq.data   = r_data;
        o_stall_m     = 1'b1;
      end
      S_DONE:  o_done = !r_kill;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr   <= '0;
      r_size   <= '0;
      r_strobe <= '0;
      r_data   <= '0;
      r_kill   <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (w_accept) begin
        r_addr   <= i_mreq.addr;
        r_size   <= i_mreq.size;
        r_strobe <= i_mreq.strobe;
        r_data   <= i_mreq.data;
      end
      // A squashed instruction still finishes on the bus; only its done pulse is suppressed.
      if (r_state == S_DONE)
        r_kill <= 1'b0;
      else if (r_state == S_BUSY && i_flush)
        r_kill <= 1'b1;
      if (w_timeout)
        r_rdata <= '0;
      else if (r_state == S_BUSY && i_dresp.data_ok)
        r_rdata <= i_dresp.data;
    end
  end

  assign o_rdata = r_rdata;

endmodule
